// File: rtl/a_register_pkg.sv
// Shared constants for the TD4 register cells.
// Latency: n/a (constants only).
// Backpressure: n/a.
package a_register_pkg;

    // Native data width of the TD4 datapath (A, B and PC are all this wide).
    localparam int TD4_WIDTH = 4;

endpackage

// File: rtl/a_register_pc.sv
// Program counter: the register cell with counting enabled.
// Latency: one CLK edge, same as the underlying cell.
// Backpressure: none; EN=0 stalls the PC, CLR returns it to 0.
//
// Ports: identical to a_register (CLK, CLR, EN, LOAD, Im, Out).
module pc
    import a_register_pkg::*;
#(
    parameter int WIDTH = TD4_WIDTH
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] Im,
    output logic [WIDTH-1:0] Out
);

    a_register #(
        .WIDTH (WIDTH),
        .COUNT (1'b1)
    ) u_cell (
        .CLK  (CLK),
        .CLR  (CLR),
        .EN   (EN),
        .LOAD (LOAD),
        .Im   (Im),
        .Out  (Out)
    );

endmodule

// File: rtl/a_register.sv
// 74HC161-style loadable register cell: A/B register (COUNT=0) or PC (COUNT=1).
// Latency: load/increment visible on Out one CLK edge after inputs are sampled.
// Backpressure: none; EN=0 freezes the cell, CLR wins over everything.
//
// Ports:
//   CLK  - clock, all updates on rising edge
//   CLR  - synchronous active-high clear, forces Out to 0
//   EN   - active-high enable, gates load and count
//   LOAD - active-high parallel-load select
//   Im   - parallel-load data
//   Out  - registered value, driven straight from the flops
module a_register
    import a_register_pkg::*;
#(
    parameter int WIDTH = TD4_WIDTH,
    parameter bit COUNT = 1'b0
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] Im,
    output logic [WIDTH-1:0] Out
);

    logic [WIDTH-1:0] value_q;

    // No power-on value: the cell is undefined until the first CLR edge,
    // matching the discrete counter part it models.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            value_q <= '0;
        end else if (EN) begin
            if (LOAD) begin
                value_q <= Im;
            end else if (COUNT) begin
                // Natural wrap modulo 2^WIDTH; no ripple-carry output.
                value_q <= value_q + WIDTH'(1);
            end
        end
    end

    assign Out = value_q;

endmodule

// File: tb/tb_a_register.sv
// Bench for the register cell used as an A register (COUNT=0) and as a PC (COUNT=1).
module tb_a_register;

    logic       clk = 1'b0;
    logic       clr_a, en_a, load_a;
    logic [3:0] im_a, out_a;
    logic       clr_p, en_p, load_p;
    logic [3:0] im_p, out_p;

    int vectors    = 0;
    int miscompares = 0;
    int exp_a      = 0;
    int exp_p      = 0;

    always #5 clk = ~clk;

    a_register #(.WIDTH(4), .COUNT(1'b0)) u_areg (
        .CLK(clk), .CLR(clr_a), .EN(en_a), .LOAD(load_a), .Im(im_a), .Out(out_a)
    );

    pc #(.WIDTH(4)) u_pc (
        .CLK(clk), .CLR(clr_p), .EN(en_p), .LOAD(load_p), .Im(im_p), .Out(out_p)
    );

    // Reference behaviour as a plain priority list over integers.
    function automatic int ref_next(int cur, bit clr, bit en, bit load, int im, bit count);
        if (clr)   return 0;
        if (!en)   return cur;
        if (load)  return im % 16;
        if (count) return (cur + 1) % 16;
        return cur;
    endfunction

    // Advance one edge, updating the model from the inputs present at that edge,
    // then settle 1 time unit past the edge before anyone samples.
    task automatic cycle();
        exp_a = ref_next(exp_a, clr_a, en_a, load_a, int'(im_a), 1'b0);
        exp_p = ref_next(exp_p, clr_p, en_p, load_p, int'(im_p), 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr_a = 1; en_a = 1; load_a = 0; im_a = 4'($urandom);
        clr_p = 1; en_p = 1; load_p = 0; im_p = 4'($urandom);
        for (int i = 0; i < 2; i++) begin
            cycle();
            vectors++;
            if (out_a !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_a edge%0d: out=%0d expected=0", i, out_a);
            end
            vectors++;
            if (out_p !== 4'd0) begin
                miscompares++;
                $display("FAIL reset_pc edge%0d: out=%0d expected=0", i, out_p);
            end
        end
        clr_a = 0; clr_p = 0; en_p = 0;
    endtask

    task automatic test_a_load();
        logic [3:0] pat [3];
        pat[0] = 4'b0001; pat[1] = 4'b0010; pat[2] = 4'b0100;
        load_a = 1; en_a = 1;
        for (int i = 0; i < 3; i++) begin
            im_a = pat[i];
            cycle();
            vectors++;
            if (out_a !== pat[i]) begin
                miscompares++;
                $display("FAIL a_load%0d: out=%0d expected=%0d", i, out_a, pat[i]);
            end
        end
        load_a = 0; im_a = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            cycle();
            vectors++;
            if (out_a !== 4'd4) begin
                miscompares++;
                $display("FAIL a_hold%0d: out=%0d expected=4", i, out_a);
            end
        end
    endtask

    task automatic test_between_edges();
        // Glitch LOAD/Im mid-cycle and restore before the edge; Out must not move.
        load_a = 1; im_a = 4'd9;
        #2;
        vectors++;
        if (out_a !== 4'd4) begin
            miscompares++;
            $display("FAIL comb_path: out=%0d expected=4", out_a);
        end
        load_a = 0; im_a = 4'd0;
        cycle();
        vectors++;
        if (out_a !== 4'd4) begin
            miscompares++;
            $display("FAIL glitch_ignored: out=%0d expected=4", out_a);
        end
    endtask

    task automatic test_pc_wrap();
        clr_p = 1; en_p = 1; load_p = 0;
        cycle();
        clr_p = 0;
        for (int i = 1; i <= 16; i++) begin
            cycle();
            vectors++;
            if (out_p !== 4'(i % 16)) begin
                miscompares++;
                $display("FAIL pc_count step%0d: out=%0d expected=%0d", i, out_p, i % 16);
            end
        end
    endtask

    task automatic test_pc_jump();
        en_p = 1; load_p = 1; im_p = 4'd5;
        cycle();
        vectors++;
        if (out_p !== 4'd5) begin
            miscompares++;
            $display("FAIL pc_preload: out=%0d expected=5", out_p);
        end
        im_p = 4'b1100;
        cycle();
        vectors++;
        if (out_p !== 4'd12) begin
            miscompares++;
            $display("FAIL pc_jump: out=%0d expected=12", out_p);
        end
        load_p = 0;
        for (int i = 13; i <= 14; i++) begin
            cycle();
            vectors++;
            if (out_p !== 4'(i)) begin
                miscompares++;
                $display("FAIL pc_after_jump: out=%0d expected=%0d", out_p, i);
            end
        end
    endtask

    task automatic test_enable();
        // A holds 4, PC holds 14 from the preceding tests.
        en_a = 0; load_a = 1; im_a = 4'd11;
        en_p = 0; load_p = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            vectors++;
            if (out_a !== 4'd4) begin
                miscompares++;
                $display("FAIL en_gate_load%0d: out=%0d expected=4", i, out_a);
            end
            vectors++;
            if (out_p !== 4'd14) begin
                miscompares++;
                $display("FAIL en_gate_count%0d: out=%0d expected=14", i, out_p);
            end
        end
        en_a = 1; clr_a = 1; load_a = 1; im_a = 4'b1111;
        cycle();
        vectors++;
        if (out_a !== 4'd0) begin
            miscompares++;
            $display("FAIL clr_over_load: out=%0d expected=0", out_a);
        end
        clr_a = 0; load_a = 0;
    endtask

    task automatic test_mid_reset();
        en_p = 1; load_p = 1; im_p = 4'd6;
        cycle();
        load_p = 0;
        cycle();
        vectors++;
        if (out_p !== 4'd7) begin
            miscompares++;
            $display("FAIL pc_at7: out=%0d expected=7", out_p);
        end
        clr_p = 1;
        cycle();
        vectors++;
        if (out_p !== 4'd0) begin
            miscompares++;
            $display("FAIL mid_reset: out=%0d expected=0", out_p);
        end
        clr_p = 0;
        cycle();
        vectors++;
        if (out_p !== 4'd1) begin
            miscompares++;
            $display("FAIL resume_after_clr: out=%0d expected=1", out_p);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clr_a  = ($urandom_range(0, 11) == 0);
            en_a   = ($urandom_range(0, 3) != 0);
            load_a = $urandom_range(0, 1);
            im_a   = 4'($urandom);
            clr_p  = ($urandom_range(0, 15) == 0);
            en_p   = ($urandom_range(0, 3) != 0);
            load_p = ($urandom_range(0, 4) == 0);
            im_p   = 4'($urandom);
            cycle();
            vectors++;
            if (out_a !== 4'(exp_a)) begin
                miscompares++;
                $display("FAIL rand_a cyc%0d: out=%0d expected=%0d", i, out_a, exp_a);
            end
            vectors++;
            if (out_p !== 4'(exp_p)) begin
                miscompares++;
                $display("FAIL rand_pc cyc%0d: out=%0d expected=%0d", i, out_p, exp_p);
            end
        end
    endtask

    initial begin
        clr_a = 0; en_a = 0; load_a = 0; im_a = '0;
        clr_p = 0; en_p = 0; load_p = 0; im_p = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_a_load();
        test_between_edges();
        test_pc_wrap();
        test_pc_jump();
        test_enable();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
